// File: rtl/shift_sched_if.sv
// Request, shared-shifter and response signals of the shift scheduler.
// slave is the scheduler's view; master is the surrounding system's view.
interface shift_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_x;
    logic [4:0]  req0_s;
    logic [1:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_x;
    logic [4:0]  req1_s;
    logic [1:0]  req1_op;

    logic [31:0] sh_x;
    logic [4:0]  sh_s;
    logic        sh_left;
    logic        sh_log;
    logic [31:0] sh_z;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_id;

    modport slave (
        input  req0_valid, req0_x, req0_s, req0_op,
        output req0_ready,
        input  req1_valid, req1_x, req1_s, req1_op,
        output req1_ready,
        output sh_x, sh_s, sh_left, sh_log,
        input  sh_z,
        output rsp_valid, rsp_z, rsp_id,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_x, req0_s, req0_op,
        input  req0_ready,
        output req1_valid, req1_x, req1_s, req1_op,
        input  req1_ready,
        input  sh_x, sh_s, sh_left, sh_log,
        output sh_z,
        input  rsp_valid, rsp_z, rsp_id,
        output rsp_ready
    );
endinterface

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler for one shared combinational barrel shifter.
// Rotate-left is built from a left pass followed by a logical-right pass ORed in.
//
// state | meaning
// IDLE  | arbitrate; READY combinational from VALID
// PASS1 | main shift of the latched operand, result captured
// PASS2 | rotate only: right shift by (32-S) ORed into result
// RESP  | result presented until consumer accepts
module shift_sched #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    shift_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        prio;
    logic [31:0] x_q;
    logic [4:0]  s_q;
    logic [1:0]  op_q;
    logic        id_q;
    logic [31:0] result_q;
    logic [31:0] rsp_z_q;

    logic        gnt0;
    logic        gnt1;
    logic        hs;
    logic        rdy0;
    logic        rdy1;
    logic [31:0] sh_x;
    logic [4:0]  sh_s;
    logic        sh_left;
    logic        sh_log;
    logic        rsp_valid;
    logic [31:0] result_nxt;

    // Lone requester always wins; on contention the priority holder wins.
    assign gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio);
    assign gnt1 = bus.req1_valid & (~bus.req0_valid |  prio);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hs         = 1'b0;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        sh_x       = '0;
        sh_s       = '0;
        sh_left    = 1'b0;
        sh_log     = 1'b0;
        rsp_valid  = 1'b0;
        result_nxt = result_q;
        case (state)
            IDLE: begin
                rdy0 = gnt0;
                rdy1 = gnt1;
                hs   = gnt0 | gnt1;
                if (hs) begin
                    state_nxt = PASS1;
                end
            end
            PASS1: begin
                sh_x       = x_q;
                sh_s       = s_q;
                sh_left    = op_q[1];
                sh_log     = ~op_q[1] & op_q[0];
                result_nxt = bus.sh_z;
                if (op_q == 2'b11 && s_q != 5'd0) begin
                    state_nxt = PASS2;
                end else begin
                    state_nxt = RESP;
                end
            end
            PASS2: begin
                sh_x       = x_q;
                sh_s       = 5'd0 - s_q;
                sh_log     = 1'b1;
                result_nxt = result_q | bus.sh_z;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            rdy0      = 1'b0;
            rdy1      = 1'b0;
            sh_x      = '0;
            sh_s      = '0;
            sh_left   = 1'b0;
            sh_log    = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    // rsp_z_q only loads on entry to RESP so the visible result never shows
    // the half-built rotate value.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= RR_INIT;
            x_q      <= '0;
            s_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            rsp_z_q  <= '0;
        end else begin
            if (hs) begin
                x_q  <= gnt1 ? bus.req1_x  : bus.req0_x;
                s_q  <= gnt1 ? bus.req1_s  : bus.req0_s;
                op_q <= gnt1 ? bus.req1_op : bus.req0_op;
                id_q <= gnt1;
                prio <= ~prio;
            end
            result_q <= result_nxt;
            if (state_nxt == RESP && state != RESP) begin
                rsp_z_q <= result_nxt;
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.sh_x       = sh_x;
    assign bus.sh_s       = sh_s;
    assign bus.sh_left    = sh_left;
    assign bus.sh_log     = sh_log;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_z      = rst ? 32'd0 : rsp_z_q;
    assign bus.rsp_id     = id_q;

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter: RR_INIT, default 0, selects the requester that has priority after reset (0 or 1).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQn_VALID  input  1  (n=0,1) requester n presents an operation.
REQ-005 REQn_READY  output  1  (n=0,1) scheduler accepts requester n's operation this cycle.
REQ-006 REQn_X  input  32  (n=0,1) operand; REQn_S  input  5  shift amount.
REQ-007 REQn_OP  input  2  (n=0,1) operation: 00 arithmetic right, 01 logical right, 10 left, 11 rotate left.
REQ-008 SH_X  output  32  operand to the shared shifter.
REQ-009 SH_S  output  5  shift amount to the shared shifter.
REQ-010 SH_LEFT, SH_LOG  output  1 each  direction and logical/arithmetic select to the shared shifter, encoded {SH_LEFT,SH_LOG} = 00 arith right, 01 logical right, 10/11 left.
REQ-011 SH_Z  input  32  combinational result from the shared shifter.
REQ-012 RSP_VALID  output  1  result available.
REQ-013 RSP_READY  input  1  consumer accepts the result.
REQ-014 RSP_Z  output  32  result; RSP_ID  output  1  index of the requester that issued it.

Function
REQ-015 FSM states SHALL be IDLE, PASS1, PASS2, RESP; exactly one request is in flight at a time.
REQ-016 IDLE: the grant goes to the single valid requester, or to the priority requester if both are valid; only the granted REQn_READY is high, and READY is combinational from VALID in IDLE only.
REQ-017 Handshake (VALID&READY in IDLE) SHALL latch X, S, OP and ID, toggle priority to the other requester, and move to PASS1.
REQ-018 No handshake in IDLE SHALL leave state and priority unchanged.
REQ-019 PASS1: SH_X/SH_S = latched X/S; SH_LEFT/SH_LOG from OP (rotate drives 10); SH_Z captured into the result register at the cycle end.
REQ-020 PASS1 -> PASS2 if OP=11 and S!=0; otherwise PASS1 -> RESP.
REQ-021 PASS2: SH_X = latched X, SH_S = (32-S) mod 32 (5-bit two's-complement negate of S), {SH_LEFT,SH_LOG}=01; result register <= result | SH_Z; then -> RESP.
REQ-022 Rotate by S=0 SHALL complete in PASS1 only, with result = X.
REQ-023 Outside PASS1/PASS2, SH_X, SH_S, SH_LEFT and SH_LOG SHALL be 0.
REQ-024 RESP: RSP_VALID=1 with RSP_Z/RSP_ID stable; hold until RSP_READY=1, then -> IDLE on the next edge.
REQ-025 RSP_VALID SHALL be 0 in every state other than RESP; RSP_Z holds its last value outside RESP.
REQ-026 Latency from handshake edge t: RSP_VALID high at t+2 for ops 00/01/10 and for rotate with S=0; t+3 for rotate with S!=0.
REQ-027 Maximum throughput is one operation per 3 cycles (4 for rotate); REQn_READY SHALL be 0 in PASS1, PASS2 and RESP.
REQ-028 REQn_VALID changes during PASS1/PASS2/RESP SHALL NOT affect the operation in flight.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE, priority=RR_INIT, result register=0, RSP_ID=0, regardless of current state (an operation in flight is discarded with no response).
REQ-030 While RST=1, REQ0_READY, REQ1_READY, RSP_VALID, SH_* and RSP_Z SHALL be 0.

Verification
REQ-031 REQ0 only, X=0x80000010, S=4, OP=00, RSP_READY=1 -> RSP_Z=0xF8000001, RSP_ID=0, RSP_VALID at t+2 for one cycle.
REQ-032 REQ1 only, X=0x80000010, S=4, OP=01, then OP=10 -> RSP_Z=0x08000001, then RSP_Z=0x00000100, both with RSP_ID=1.
REQ-033 REQ0 only, rotate X=0x12345678, S=8 -> PASS2 shows SH_S=24 and {SH_LEFT,SH_LOG}=01; RSP_Z=0x34567812 at t+3; rotate with S=0 -> RSP_Z=X at t+2.
REQ-034 Both VALID continuously, RR_INIT=0 -> grants alternate 0,1,0,1; RSP_ID sequence matches; never two READYs in one cycle.
REQ-035 Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID and RSP_Z held, REQn_READY=0 throughout; IDLE is reached one edge after RSP_READY=1.
REQ-036 RST pulsed in PASS2 of a rotate -> next cycle IDLE, RSP_VALID=0, no response emitted, priority=RR_INIT.
